arc4_key_search_ctrl: RTL

Sequencer that runs a single arc4 decryption core over a range of 24-bit keys. For each candidate key it resets the core, starts it, and snoops its plaintext writes. It aborts the attempt on the first non-printable plaintext byte; if the core completes cleanly, it reports the key. It sits between the top-level crack wrapper (en/rdy plus key range) and one arc4 instance, whose S/CT/PT memories stay wired to the core.

---
 rtl/arc4_search_pkg.sv | 17 +
 rtl/pt_byte_filter.sv | 32 +++
 rtl/arc4_key_search_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/arc4_search_pkg.sv
// Shared types and defaults for the arc4 key-search sequencer.
package arc4_search_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        WAIT_RDY = 3'd2,
        START    = 3'd3,
        RUN      = 3'd4,
        ADVANCE  = 3'd5,
        FOUND    = 3'd6
    } state_t;

    localparam logic [7:0] CHAR_LO_DEF = 8'h20;
    localparam logic [7:0] CHAR_HI_DEF = 8'h7E;

endpackage

// File: rtl/pt_byte_filter.sv
// Snoops the core's plaintext writes and flags any non-printable byte.
module pt_byte_filter
    import arc4_search_pkg::*;
#(
    parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
    parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       pt_wren,
    input  logic [7:0] pt_addr,
    input  logic [7:0] pt_wrdata,
    output logic       bad
);

    logic bad_now;
    logic bad_q;

    // Address 0 carries the message length, not text.
    assign bad_now = pt_wren && (pt_addr != 8'd0) &&
                     ((pt_wrdata < CHAR_LO) || (pt_wrdata > CHAR_HI));

    always_ff @(posedge clk) begin
        if (!rst_n)       bad_q <= 1'b0;
        else if (clr)     bad_q <= 1'b0;
        else if (bad_now) bad_q <= 1'b1;
    end

    assign bad = bad_now | bad_q;

endmodule

// File: rtl/arc4_key_search_ctrl.sv
// Walks a key range through one arc4 core, aborting attempts on non-printable output.
module arc4_key_search_ctrl
    import arc4_search_pkg::*;
#(
    parameter int         KEY_W      = 24,
    parameter int         RST_CYCLES = 1,
    parameter logic [7:0] CHAR_LO    = CHAR_LO_DEF,
    parameter logic [7:0] CHAR_HI    = CHAR_HI_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key_start,
    input  logic [KEY_W-1:0] key_end,
    input  logic [KEY_W-1:0] key_stride,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic [KEY_W-1:0] attempt_cnt,
    output logic             core_rst_n,
    output logic             core_en,
    input  logic             core_rdy,
    output logic [KEY_W-1:0] core_key,
    input  logic             pt_wren,
    input  logic [7:0]       pt_addr,
    input  logic [7:0]       pt_wrdata
);

    localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES - 1);

    state_t           state, state_nxt;
    logic [KEY_W-1:0] cur_key, key_end_q, stride_q;
    logic [3:0]       rst_cnt;
    logic             run_first;
    logic             bad;
    logic [KEY_W:0]   sum;
    logic             range_empty, adv_done;

    pt_byte_filter #(.CHAR_LO(CHAR_LO), .CHAR_HI(CHAR_HI)) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state == START),
        .pt_wren   (pt_wren),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .bad       (bad)
    );

    // Extra bit catches wrap past the top of the key space.
    assign sum         = {1'b0, cur_key} + {1'b0, stride_q};
    assign adv_done    = sum[KEY_W] || (sum[KEY_W-1:0] > key_end_q);
    assign range_empty = key_start > key_end;

    assign core_rst_n = rst_n & (state != CORE_RST);
    assign core_key   = cur_key;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        core_en   = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (en && !range_empty) state_nxt = CORE_RST;
            end
            CORE_RST: if (rst_cnt == 4'd0) state_nxt = WAIT_RDY;
            WAIT_RDY: if (core_rdy) state_nxt = START;
            START: begin
                core_en   = 1'b1;
                state_nxt = RUN;
            end
            // The core still shows its old rdy on the first RUN cycle.
            RUN: begin
                if (bad)                        state_nxt = ADVANCE;
                else if (core_rdy && !run_first) state_nxt = FOUND;
            end
            ADVANCE: state_nxt = adv_done ? IDLE : CORE_RST;
            FOUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_key     <= '0;
            key_end_q   <= '0;
            stride_q    <= '0;
            rst_cnt     <= '0;
            run_first   <= 1'b0;
            key_out     <= '0;
            key_valid   <= 1'b0;
            attempt_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (en) begin
                    cur_key     <= key_start;
                    key_end_q   <= key_end;
                    stride_q    <= (key_stride == '0) ? KEY_W'(1) : key_stride;
                    rst_cnt     <= RST_LOAD;
                    key_valid   <= 1'b0;
                    attempt_cnt <= '0;
                end
                CORE_RST: if (rst_cnt != 4'd0) rst_cnt <= rst_cnt - 4'd1;
                START: begin
                    attempt_cnt <= attempt_cnt + KEY_W'(1);
                    run_first   <= 1'b1;
                end
                RUN: run_first <= 1'b0;
                ADVANCE: if (!adv_done) begin
                    cur_key <= sum[KEY_W-1:0];
                    rst_cnt <= RST_LOAD;
                end
                FOUND: begin
                    key_out   <= cur_key;
                    key_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
